fmm_m_e_bram_responder: RTL and testbench

// Memory-side responder for the M_e coefficient matrix, serving HLS reduce loops such as greedy_potential_reduce.
// - Port 0 is a write-only initiator port (address0/ce0/we0/d0); port 1 is a read-only port (address1/ce1/q1) with 1-cycle latency.
// - Adds a maintenance engine: clears a region to zero, or streams a region out over valid/ready for debug readback.
// - Sits between the kernel's pipelined loops and the inferred block RAM.

---
 rtl/fmm_m_e_bram_responder_if.sv | 37 +++
 rtl/fmm_m_e_bram_responder.sv | 182 ++++++++++++++++++
 tb/tb_fmm_m_e_bram_responder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmm_m_e_bram_responder_if.sv
// Bus bundle for the M_e responder: kernel BRAM ports, maintenance control
// and the debug dump stream.
interface fmm_m_e_bram_responder_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] M_e_address0;
    logic              M_e_ce0;
    logic              M_e_we0;
    logic [DATA_W-1:0] M_e_d0;
    logic [ADDR_W-1:0] M_e_address1;
    logic              M_e_ce1;
    logic [DATA_W-1:0] M_e_q1;
    logic              ctl_start;
    logic              ctl_op;
    logic [ADDR_W-1:0] ctl_base;
    logic [ADDR_W-1:0] ctl_len;
    logic              ctl_idle;
    logic              ctl_done;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              err_conflict;

    modport master (
        output M_e_address0, M_e_ce0, M_e_we0, M_e_d0, M_e_address1, M_e_ce1,
               ctl_start, ctl_op, ctl_base, ctl_len, dump_ready,
        input  M_e_q1, ctl_idle, ctl_done, dump_valid, dump_data, dump_last, err_conflict
    );

    modport slave (
        input  M_e_address0, M_e_ce0, M_e_we0, M_e_d0, M_e_address1, M_e_ce1,
               ctl_start, ctl_op, ctl_base, ctl_len, dump_ready,
        output M_e_q1, ctl_idle, ctl_done, dump_valid, dump_data, dump_last, err_conflict
    );
endinterface

// File: rtl/fmm_m_e_bram_responder.sv
// M_e coefficient BRAM with a write-only kernel port, a 1-cycle read port and
// a maintenance engine that clears a region or streams it out for readback.
module fmm_m_e_bram_responder #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    fmm_m_e_bram_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_DUMP_RD  = 3'd2;
    localparam logic [2:0] S_DUMP_OUT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [2:0]        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic [ADDR_W-1:0] r_len, w_len_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_idle, w_idle_nxt;
    logic              r_done, w_done_nxt;
    logic              r_dvalid, w_dvalid_nxt;
    logic              r_dlast, w_dlast_nxt;
    logic              r_err, w_err_nxt;
    logic [DATA_W-1:0] r_q1;
    logic [DATA_W-1:0] r_dump_data;

    logic [ADDR_W-1:0] w_eng_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_we;
    logic              w_kernel_rd;
    logic              w_dump_load;
    logic              w_cnt_last;
    logic              w_bypass;

    // Region address wraps naturally at the top of the address space
    assign w_eng_addr = ADDR_W'(r_base + r_cnt);
    assign w_cnt_last = (r_cnt == ADDR_W'(r_len - ADDR_W'(1)));
    assign w_rd_addr  = (r_state == S_IDLE) ? bus.M_e_address1 : w_eng_addr;
    assign w_bypass   = w_mem_we && (bus.M_e_address0 == bus.M_e_address1);

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_idle   <= 1'b1;
            r_done   <= 1'b0;
            r_dvalid <= 1'b0;
            r_dlast  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_base   <= w_base_nxt;
            r_len    <= w_len_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idle   <= w_idle_nxt;
            r_done   <= w_done_nxt;
            r_dvalid <= w_dvalid_nxt;
            r_dlast  <= w_dlast_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state, engine datapath control and kernel port arbitration
    always_comb begin
        w_state_nxt  = r_state;
        w_base_nxt   = r_base;
        w_len_nxt    = r_len;
        w_cnt_nxt    = r_cnt;
        w_idle_nxt   = r_idle;
        w_done_nxt   = 1'b0;
        w_dvalid_nxt = r_dvalid;
        w_dlast_nxt  = r_dlast;
        w_err_nxt    = r_err;
        w_mem_we     = 1'b0;
        w_mem_waddr  = bus.M_e_address0;
        w_mem_wdata  = bus.M_e_d0;
        w_kernel_rd  = 1'b0;
        w_dump_load  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_mem_we    = bus.M_e_ce0 && bus.M_e_we0;
                w_kernel_rd = bus.M_e_ce1;
                if (bus.ctl_start) begin
                    w_base_nxt = bus.ctl_base;
                    w_len_nxt  = bus.ctl_len;
                    w_cnt_nxt  = '0;
                    w_idle_nxt = 1'b0;
                    if (bus.ctl_len == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = bus.ctl_op ? S_DUMP_RD : S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = w_eng_addr;
                w_mem_wdata = '0;
                if (w_cnt_last) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = ADDR_W'(r_cnt + ADDR_W'(1));
                end
            end
            S_DUMP_RD: begin
                w_dump_load  = 1'b1;
                w_dvalid_nxt = 1'b1;
                w_dlast_nxt  = w_cnt_last;
                w_state_nxt  = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (bus.dump_ready) begin
                    w_dvalid_nxt = 1'b0;
                    w_dlast_nxt  = 1'b0;
                    if (r_dlast) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = ADDR_W'(r_cnt + ADDR_W'(1));
                        w_state_nxt = S_DUMP_RD;
                    end
                end
            end
            S_DONE: begin
                w_idle_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idle_nxt  = 1'b1;
            end
        endcase

        if ((r_state != S_IDLE) && (bus.M_e_ce0 || bus.M_e_ce1)) begin
            w_err_nxt = 1'b1;
        end
    end

    // Storage array: no reset so it maps onto block RAM
    always_ff @(posedge ap_clk) begin
        if (!ap_rst && w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Shared read port; kernel reads see a same-cycle write first
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_q1        <= '0;
            r_dump_data <= '0;
        end else begin
            if (w_kernel_rd) begin
                r_q1 <= w_bypass ? bus.M_e_d0 : r_mem[w_rd_addr];
            end
            if (w_dump_load) begin
                r_dump_data <= r_mem[w_rd_addr];
            end
        end
    end

    assign bus.M_e_q1       = r_q1;
    assign bus.ctl_idle     = r_idle;
    assign bus.ctl_done     = r_done;
    assign bus.dump_valid   = r_dvalid;
    assign bus.dump_data    = r_dump_data;
    assign bus.dump_last    = r_dlast;
    assign bus.err_conflict = r_err;
endmodule

// File: tb/tb_fmm_m_e_bram_responder.sv
// Scoreboard bench for fmm_m_e_bram_responder: directed cases plus random
// kernel traffic and maintenance operations against a sparse memory model.
module tb_fmm_m_e_bram_responder;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 32;
    localparam int DEPTH = 1 << ADDR_W;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } dump_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmm_m_e_bram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    fmm_m_e_bram_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ap_clk(clk),
        .ap_rst(rst),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [int];
    logic [31:0] exp_q1 [$];
    dump_t       exp_dump [$];
    dump_t       mon_e;
    bit          tb_rd_req = 1'b0;
    bit          rd_pend = 1'b0;
    int          dump_seen = 0;
    int          dump_vcyc = 0;
    logic [31:0] last_q1_exp = '0;
    int          pool [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected read data and dump words as the DUT presents them
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL q1_unexpected: read completed with no expectation queued");
            end else begin
                check("q1", bus.M_e_q1, exp_q1.pop_front());
            end
        end
        rd_pend = tb_rd_req;
        if (bus.dump_valid) begin
            dump_vcyc++;
            if (exp_dump.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dump_unexpected: dump_valid with data 0x%08h, none expected", bus.dump_data);
            end else begin
                mon_e = exp_dump[0];
                check("dump_data", bus.dump_data, mon_e.data);
                check("dump_last", 32'(bus.dump_last), 32'(mon_e.last));
                if (bus.dump_ready) begin
                    void'(exp_dump.pop_front());
                    dump_seen++;
                end
            end
        end
    end

    // One kernel-port cycle; the expected read value comes from the model
    task automatic kcycle(input bit ce0, input bit we0, input int a0, input logic [31:0] d0,
                          input bit ce1, input int a1);
        logic [31:0] e;
        bus.M_e_ce0      = ce0;
        bus.M_e_we0      = we0;
        bus.M_e_address0 = 17'(a0);
        bus.M_e_d0       = d0;
        bus.M_e_ce1      = ce1;
        bus.M_e_address1 = 17'(a1);
        if (ce1) begin
            e = (ce0 && we0 && a0 == a1) ? d0 : mdl[a1];
            exp_q1.push_back(e);
            last_q1_exp = e;
        end
        tb_rd_req = ce1;
        if (ce0 && we0) mdl[a0] = d0;
        tick();
        bus.M_e_ce0 = 1'b0;
        bus.M_e_we0 = 1'b0;
        bus.M_e_ce1 = 1'b0;
        tb_rd_req   = 1'b0;
    endtask

    task automatic kread(input int a);
        kcycle(1'b0, 1'b0, 0, 32'h0, 1'b1, a);
    endtask

    // Maintenance op; mode 0 = ready high, 1 = random ready, 2 = stall word 2 for 4 cycles
    task automatic run_op(input bit op, input int base, input int len, input int mode,
                          input bit inj, output int done_cyc);
        int    stall_left;
        int    ndone;
        bit    finished;
        dump_t t;
        stall_left = 4;
        ndone      = 0;
        finished   = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (op == 1'b0) begin
                mdl[(base + i) % DEPTH] = 32'h0;
            end else begin
                t.data = mdl[(base + i) % DEPTH];
                t.last = (i == len - 1);
                exp_dump.push_back(t);
            end
        end
        dump_seen      = 0;
        dump_vcyc      = 0;
        bus.ctl_start  = 1'b1;
        bus.ctl_op     = op;
        bus.ctl_base   = 17'(base);
        bus.ctl_len    = 17'(len);
        tick();
        bus.ctl_start  = 1'b0;
        done_cyc       = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            case (mode)
                0: bus.dump_ready = 1'b1;
                1: bus.dump_ready = 1'($urandom % 2);
                default: begin
                    if (dump_seen == 1 && bus.dump_valid && stall_left > 0) begin
                        bus.dump_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.dump_ready = 1'b1;
                    end
                end
            endcase
            if (inj && cyc == 2) begin
                bus.M_e_ce0      = 1'b1;
                bus.M_e_we0      = 1'b1;
                bus.M_e_address0 = 17'(pool[3]);
                bus.M_e_d0       = 32'hDEADBEEF;
                bus.M_e_ce1      = 1'b1;
                bus.M_e_address1 = 17'(pool[4]);
            end
            if (inj && cyc == 3) begin
                bus.M_e_ce0 = 1'b0;
                bus.M_e_we0 = 1'b0;
                bus.M_e_ce1 = 1'b0;
            end
            if (bus.ctl_done) begin
                if (done_cyc == 0) done_cyc = cyc;
                ndone++;
            end
            if (bus.ctl_idle) begin
                finished = 1'b1;
                break;
            end
            tick();
        end
        bus.dump_ready = 1'b1;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: engine not idle after 300 cycles (op %0d len %0d)", op, len);
        end
        check("done_pulses", 32'(ndone), 32'd1);
        check("dump_queue_drained", 32'(exp_dump.size()), 32'd0);
        if (op == 1'b1) check("dump_words", 32'(dump_seen), 32'(len));
        else            check("clear_no_dump", 32'(dump_vcyc), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst              = 1'b1;
        bus.M_e_address0 = '0;
        bus.M_e_ce0      = 1'b0;
        bus.M_e_we0      = 1'b0;
        bus.M_e_d0       = '0;
        bus.M_e_address1 = '0;
        bus.M_e_ce1      = 1'b0;
        bus.ctl_start    = 1'b0;
        bus.ctl_op       = 1'b0;
        bus.ctl_base     = '0;
        bus.ctl_len      = '0;
        bus.dump_ready   = 1'b1;
        for (int i = 0; i < 16; i++) pool[i] = (i < 8) ? (32'h1FFF8 + i) : (i - 8);
        repeat (3) tick();
        rst = 1'b0;

        check("rst_q1", bus.M_e_q1, 32'h0);
        check("rst_idle", 32'(bus.ctl_idle), 32'd1);
        check("rst_done", 32'(bus.ctl_done), 32'd0);
        check("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
        check("rst_dump_data", bus.dump_data, 32'h0);
        check("rst_dump_last", 32'(bus.dump_last), 32'd0);
        check("rst_err", 32'(bus.err_conflict), 32'd0);

        // Basic write then read, held while ce1 is low
        kcycle(1'b1, 1'b1, 32'h10, 32'hFFFFFFFB, 1'b0, 0);
        kread(32'h10);
        tick();
        tick();
        check("q1_hold", bus.M_e_q1, 32'hFFFFFFFB);

        // Write-first bypass and independent different-address access
        kcycle(1'b1, 1'b1, 5, 32'd3, 1'b0, 0);
        kcycle(1'b1, 1'b0, 5, 32'd99, 1'b1, 5);
        kcycle(1'b1, 1'b1, 5, 32'd7, 1'b1, 5);
        kcycle(1'b1, 1'b1, 5, 32'd3, 1'b0, 0);
        kcycle(1'b1, 1'b1, 6, 32'h99, 1'b1, 5);
        kread(6);

        for (int i = 0; i < 16; i++) kcycle(1'b1, 1'b1, pool[i], $urandom, 1'b0, 0);

        // CLEAR across the top-of-memory wrap
        run_op(1'b0, 32'h1FFFE, 4, 0, 1'b0, dc);
        check("clear_done_cycle", 32'(dc), 32'd5);
        for (int i = 5; i < 12; i++) kread(pool[i]);

        // DUMP with a 4-cycle stall on the second word
        kcycle(1'b1, 1'b1, 32'h100, 32'd1, 1'b0, 0);
        kcycle(1'b1, 1'b1, 32'h101, 32'd2, 1'b0, 0);
        kcycle(1'b1, 1'b1, 32'h102, 32'd3, 1'b0, 0);
        run_op(1'b1, 32'h100, 3, 2, 1'b0, dc);

        // Empty operations
        run_op(1'b0, pool[2], 0, 0, 1'b0, dc);
        checks++;
        if (dc < 1 || dc > 2) begin
            errors++;
            $display("FAIL len0_clear_done: done after %0d cycles, required 1..2", dc);
        end
        kread(pool[2]);
        run_op(1'b1, pool[2], 0, 0, 1'b0, dc);
        checks++;
        if (dc < 1 || dc > 2) begin
            errors++;
            $display("FAIL len0_dump_done: done after %0d cycles, required 1..2", dc);
        end
        check("no_err_yet", 32'(bus.err_conflict), 32'd0);

        // Random kernel traffic with frequent address collisions
        for (int n = 0; n < 300; n++) begin
            int a0;
            int a1;
            a0 = pool[$urandom % 16];
            a1 = ($urandom % 4 == 0) ? a0 : pool[$urandom % 16];
            kcycle(1'($urandom % 2), 1'($urandom % 4 != 0), a0, $urandom, 1'($urandom % 2), a1);
        end

        // Random maintenance ops, each followed by readback of the pool
        for (int n = 0; n < 20; n++) begin
            bit op;
            int base;
            int len;
            op   = 1'($urandom % 2);
            base = (32'h1FFF8 + int'($urandom % 8)) % DEPTH;
            len  = int'($urandom % 9);
            run_op(op, base, len, 1, 1'b0, dc);
            for (int k = 0; k < 6; k++) kread(pool[$urandom % 16]);
        end

        // Kernel access during CLEAR is ignored and flagged
        kread(pool[4]);
        run_op(1'b0, 0, 4, 0, 1'b1, dc);
        check("conflict_err", 32'(bus.err_conflict), 32'd1);
        check("conflict_q1_frozen", bus.M_e_q1, last_q1_exp);
        kread(pool[3]);
        kread(pool[4]);

        // Reset in the middle of a stalled DUMP
        kcycle(1'b1, 1'b1, 32'h200, 32'hA, 1'b0, 0);
        kcycle(1'b1, 1'b1, 32'h201, 32'hB, 1'b0, 0);
        kcycle(1'b1, 1'b1, 32'h202, 32'hC, 1'b0, 0);
        mon_e.data = 32'hA;
        mon_e.last = 1'b0;
        exp_dump.push_back(mon_e);
        bus.dump_ready = 1'b0;
        bus.ctl_start  = 1'b1;
        bus.ctl_op     = 1'b1;
        bus.ctl_base   = 17'h200;
        bus.ctl_len    = 17'd3;
        tick();
        bus.ctl_start = 1'b0;
        repeat (3) tick();
        check("stall_valid", 32'(bus.dump_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_idle", 32'(bus.ctl_idle), 32'd1);
        check("midrst_valid", 32'(bus.dump_valid), 32'd0);
        check("midrst_done", 32'(bus.ctl_done), 32'd0);
        check("midrst_err", 32'(bus.err_conflict), 32'd0);
        check("midrst_q1", bus.M_e_q1, 32'h0);
        exp_dump.delete();
        rst            = 1'b0;
        bus.dump_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_no_done", 32'(bus.ctl_done), 32'd0);
        end
        run_op(1'b1, 32'h200, 3, 1, 1'b0, dc);

        repeat (3) tick();
        check("q1_queue_drained", 32'(exp_q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
